// File: rtl/tmp_ctrl_pkg.sv
// tmp_ctrl_pkg: shared opcodes, FSM states and constants for the TMP register controller.
// Contents: opcode_t, state_t, OP_W, TIMEOUT_CYC, CTRL_IDLE.
package tmp_ctrl_pkg;
    localparam int OP_W = 3;
    localparam int TIMEOUT_CYC = 16;
    // Control vector order: h_dir, h_pass, h_load, h_out, l_dir, l_pass, l_load, l_out, pass_address, address_dir
    localparam logic [9:0] CTRL_IDLE = 10'b0101_0101_10;
    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD_H, OP_LOAD_L, OP_STORE_H, OP_STORE_L, OP_LOAD_ADDR, OP_STORE_ADDR, OP_ILLEGAL
    } opcode_t;
    typedef enum logic [2:0] {IDLE, REQ, SETUP, XFER, RELEASE} state_t;
endpackage

// File: rtl/tmp_ctrl_if.sv
// tmp_ctrl_if: command handshake, bus arbitration and TMP register control lines.
// master = controller side (drives cmd_ready, bus_req/sel, done/err, reg_*), slave = environment.
interface tmp_ctrl_if #(parameter int CMD_W = 3);
    logic             cmd_valid;
    logic [CMD_W-1:0] cmd;
    logic             cmd_ready;
    logic             bus_req;
    logic             bus_sel;
    logic             bus_gnt;
    logic             done;
    logic             err;
    logic             reg_tmph_data_dir;
    logic             reg_tmph_pass_data;
    logic             reg_tmph_load;
    logic             reg_tmph_out;
    logic             reg_tmpl_data_dir;
    logic             reg_tmpl_pass_data;
    logic             reg_tmpl_load;
    logic             reg_tmpl_out;
    logic             reg_tmp_pass_address;
    logic             reg_tmp_address_dir;
    modport master (
        input  cmd_valid, cmd, bus_gnt,
        output cmd_ready, bus_req, bus_sel, done, err,
               reg_tmph_data_dir, reg_tmph_pass_data, reg_tmph_load, reg_tmph_out,
               reg_tmpl_data_dir, reg_tmpl_pass_data, reg_tmpl_load, reg_tmpl_out,
               reg_tmp_pass_address, reg_tmp_address_dir
    );
    modport slave (
        output cmd_valid, cmd, bus_gnt,
        input  cmd_ready, bus_req, bus_sel, done, err,
               reg_tmph_data_dir, reg_tmph_pass_data, reg_tmph_load, reg_tmph_out,
               reg_tmpl_data_dir, reg_tmpl_pass_data, reg_tmpl_load, reg_tmpl_out,
               reg_tmp_pass_address, reg_tmp_address_dir
    );
endinterface

// File: rtl/tmp_ctrl.sv
// tmp_ctrl: sequences TMP high/low/address register transfers over an arbitrated bus.
// Ports: clk, rst_n (async active-low), bus (tmp_ctrl_if.master: cmd handshake, bus_req/sel/gnt,
// done/err pulses, reg_* controls). Optional TMP_CTRL_TIMEOUT_EN aborts REQ after TIMEOUT_CYC cycles.
module tmp_ctrl
    import tmp_ctrl_pkg::*;
#(
    parameter int CMD_W = 3
) (
    input logic        clk,
    input logic        rst_n,
    tmp_ctrl_if.master bus
);
    state_t           state, ns;
    opcode_t          op, op_nxt;
    logic [CMD_W-1:0] cmd_in;
    logic [9:0]       ctrl, ctrl_nxt;
    logic             accept, hi, lo, adr, st, ld, act, busy, timeout;
    logic             bus_req_q, bus_sel_q, done_q, err_q, ready_q;

    assign cmd_in = bus.cmd;
    assign accept = bus.cmd_valid & ready_q;

`ifdef TMP_CTRL_TIMEOUT_EN
    logic [4:0] req_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) req_cnt <= '0;
        else        req_cnt <= (state == REQ) ? req_cnt + 5'd1 : '0;
    assign timeout = (state == REQ) && !bus.bus_gnt && (req_cnt == 5'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // Everything below is computed for the next cycle so every output comes straight from a flop.
    always_comb begin
        op_nxt = accept ? opcode_t'(cmd_in[OP_W-1:0]) : op;
        ns     = state;
        unique case (state)
            IDLE:    ns = (accept && op_nxt != OP_NOP && op_nxt != OP_ILLEGAL) ? REQ : IDLE;
            REQ:     ns = bus.bus_gnt ? SETUP : (timeout ? IDLE : REQ);
            SETUP:   ns = XFER;
            XFER:    ns = RELEASE;
            RELEASE: ns = IDLE;
            default: ns = IDLE;
        endcase
        adr  = op_nxt inside {OP_LOAD_ADDR, OP_STORE_ADDR};
        hi   = adr || op_nxt inside {OP_LOAD_H, OP_STORE_H};
        lo   = adr || op_nxt inside {OP_LOAD_L, OP_STORE_L};
        st   = op_nxt inside {OP_STORE_H, OP_STORE_L, OP_STORE_ADDR};
        ld   = op_nxt inside {OP_LOAD_H, OP_LOAD_L, OP_LOAD_ADDR};
        act  = ns inside {SETUP, XFER};
        busy = ns != IDLE;
        // Address transfers use the address pass path, so the data pass lines stay off for them.
        ctrl_nxt = {
            act && hi && !adr && st, !(act && hi && !adr), (ns == XFER) && hi && ld, !(act && hi && st),
            act && lo && !adr && st, !(act && lo && !adr), (ns == XFER) && lo && ld, !(act && lo && st),
            !(act && adr), act && adr && st
        };
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_NOP;
            ctrl      <= CTRL_IDLE;
            bus_req_q <= 1'b0;
            bus_sel_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state     <= ns;
            op        <= op_nxt;
            ctrl      <= ctrl_nxt;
            bus_req_q <= busy;
            bus_sel_q <= busy && adr;
            done_q    <= (state == RELEASE) || (accept && op_nxt == OP_NOP);
            err_q     <= (accept && op_nxt == OP_ILLEGAL) || timeout;
            ready_q   <= !busy;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign {bus.reg_tmph_data_dir, bus.reg_tmph_pass_data, bus.reg_tmph_load, bus.reg_tmph_out,
            bus.reg_tmpl_data_dir, bus.reg_tmpl_pass_data, bus.reg_tmpl_load, bus.reg_tmpl_out,
            bus.reg_tmp_pass_address, bus.reg_tmp_address_dir} = ctrl;
endmodule

// File: tb/tb_tmp_ctrl.sv
// tb_tmp_ctrl: directed scoreboard bench for tmp_ctrl.
module tb_tmp_ctrl;
    import tmp_ctrl_pkg::*;

    typedef struct {bit is_err; int cyc;} exp_t;

    localparam logic [9:0] IDLE_C = 10'b0101_0101_10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t e_mon;

    tmp_ctrl_if #(.CMD_W(3)) bus();
    tmp_ctrl #(.CMD_W(3)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [9:0] ctrl = {bus.reg_tmph_data_dir, bus.reg_tmph_pass_data, bus.reg_tmph_load, bus.reg_tmph_out,
                       bus.reg_tmpl_data_dir, bus.reg_tmpl_pass_data, bus.reg_tmpl_load, bus.reg_tmpl_out,
                       bus.reg_tmp_pass_address, bus.reg_tmp_address_dir};

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_pulse(input bit is_err, input int c);
        exp_t e;
        e.is_err = is_err;
        e.cyc = c;
        q.push_back(e);
    endtask

    // Returns just after the accepting edge; a is the cycle index that edge starts.
    task automatic issue(input opcode_t op, input bit keep, output int a);
        int w = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd = op;
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("accept_wait", 0, 1);
        a = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done || bus.err) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_pulse @cyc %0d: done=%0b err=%0b, expected none", cyc, bus.done, bus.err);
                end else begin
                    e_mon = q.pop_front();
                    chk("pulse_kind_err", int'(bus.err), int'(e_mon.is_err));
                    chk("pulse_cycle", cyc, e_mon.cyc);
                end
            end
            chk("load_out_overlap", int'((bus.reg_tmph_load | bus.reg_tmpl_load) & (!bus.reg_tmph_out | !bus.reg_tmpl_out)), 0);
            chk("pass_overlap", int'(!bus.reg_tmp_pass_address & (!bus.reg_tmph_pass_data | !bus.reg_tmpl_pass_data)), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int a, a2, w;
        bus.cmd_valid = 1'b0;
        bus.cmd = 3'd0;
        bus.bus_gnt = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", int'(ctrl), int'(IDLE_C));
        chk("rst_bus_req", int'(bus.bus_req), 0);
        chk("rst_bus_sel", int'(bus.bus_sel), 0);
        chk("rst_done_err", int'({bus.done, bus.err}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(bus.cmd_ready), 1);

        // LOAD_H, grant already high
        issue(OP_LOAD_H, 1'b0, a);
        expect_pulse(1'b0, a + 4);
        @(negedge clk);
        chk("lh_req", int'({bus.bus_req, bus.bus_sel, bus.cmd_ready}), 3'b100);
        chk("lh_req_ctrl", int'(ctrl), int'(IDLE_C));
        @(negedge clk);
        chk("lh_setup", int'(ctrl), int'(10'b0001_0101_10));
        @(negedge clk);
        chk("lh_xfer", int'(ctrl), int'(10'b0011_0101_10));
        @(negedge clk);
        chk("lh_release", int'({bus.bus_req, ctrl}), int'({1'b1, IDLE_C}));
        @(negedge clk);
        chk("lh_idle", int'({bus.bus_req, bus.cmd_ready}), 2'b01);

        // STORE_ADDR, grant delayed 5 REQ cycles
        bus.bus_gnt = 1'b0;
        issue(OP_STORE_ADDR, 1'b0, a);
        expect_pulse(1'b0, a + 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sa_req", int'({bus.bus_req, bus.bus_sel}), 2'b11);
            chk("sa_req_ctrl", int'(ctrl), int'(IDLE_C));
            if (i == 4) bus.bus_gnt = 1'b1;
        end
        @(negedge clk);
        chk("sa_setup", int'(ctrl), int'(10'b0100_0100_01));
        @(negedge clk);
        chk("sa_xfer", int'(ctrl), int'(10'b0100_0100_01));
        @(negedge clk);
        chk("sa_release", int'({bus.bus_req, ctrl}), int'({1'b1, IDLE_C}));
        @(negedge clk);
        chk("sa_idle", int'({bus.bus_req, bus.bus_sel}), 0);

        // Illegal opcode then NOP, back to back
        issue(OP_ILLEGAL, 1'b1, a);
        expect_pulse(1'b1, a);
        issue(OP_NOP, 1'b0, a2);
        expect_pulse(1'b0, a2);
        chk("ill_nop_spacing", a2, a + 1);
        repeat (3) begin
            @(negedge clk);
            chk("ill_nop_quiet", int'({bus.bus_req, bus.cmd_ready}), 2'b01);
        end

        // Reset in XFER of LOAD_ADDR
        issue(OP_LOAD_ADDR, 1'b0, a);
        @(negedge clk);
        chk("la_req_sel", int'({bus.bus_req, bus.bus_sel}), 2'b11);
        @(negedge clk);
        chk("la_setup", int'(ctrl), int'(10'b0101_0101_00));
        @(negedge clk);
        chk("la_xfer", int'(ctrl), int'(10'b0111_0111_00));
        rst_n = 1'b0;
        #1;
        chk("la_rst_ctrl", int'(ctrl), int'(IDLE_C));
        chk("la_rst_bus", int'({bus.bus_req, bus.bus_sel, bus.done, bus.err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("la_after_rst", int'({bus.cmd_ready, bus.done, bus.bus_req}), 3'b100);
        end

        // LOAD_L then STORE_L with cmd_valid held
        issue(OP_LOAD_L, 1'b1, a);
        expect_pulse(1'b0, a + 4);
        issue(OP_STORE_L, 1'b0, a2);
        expect_pulse(1'b0, a2 + 4);
        chk("b2b_accept", a2, a + 5);
        repeat (2) @(negedge clk);
        chk("sl_setup", int'(ctrl), int'(10'b0101_1000_10));
        @(negedge clk);
        chk("sl_xfer", int'(ctrl), int'(10'b0101_1000_10));
        repeat (2) @(negedge clk);

        // No grant: timeout or indefinite wait
        bus.bus_gnt = 1'b0;
        issue(OP_LOAD_H, 1'b0, a);
`ifdef TMP_CTRL_TIMEOUT_EN
        expect_pulse(1'b1, a + 16);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("to_req_held", int'(bus.bus_req), 1);
        end
        @(negedge clk);
        chk("to_dropped", int'({bus.bus_req, bus.cmd_ready}), 2'b01);
        bus.bus_gnt = 1'b1;
`else
        repeat (100) begin
            @(negedge clk);
            chk("nto_req_held", int'({bus.bus_req, bus.cmd_ready}), 2'b10);
        end
        bus.bus_gnt = 1'b1;
        expect_pulse(1'b0, cyc + 4);
`endif

        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
